ext_ram_loader: RTL and testbench

EXT_RAM_LOADER -- requirements
Module: ext_ram_loader

---
 rtl/ext_ram_loader_pkg.sv | 12 +
 rtl/ext_ram_loader_frame_counter.sv | 25 ++
 rtl/ext_ram_loader.sv | 148 ++++++++++++++
 tb/tb_ext_ram_loader.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/ext_ram_loader_pkg.sv
// Shared types and defaults for the external-RAM LLR frame loader.
package ext_ram_loader_pkg;

  localparam int unsigned DEFAULT_FRAME_LEN = 256;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage

// File: rtl/ext_ram_loader_frame_counter.sv
// Modulo-FRAME_LEN counter with enable; last_c flags the final count of a frame.
module frame_counter #(
  parameter int unsigned CNT_WIDTH = 9,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  output logic [CNT_WIDTH-1:0] count,
  output logic                 last_c
);

  localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(FRAME_LEN - 1);

  assign last_c = (count == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (en) begin
      count <= last_c ? '0 : count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: rtl/ext_ram_loader.sv
// Loads one frame of LLR words into an external RAM, then streams it to the decoder.
// Optional build macro LOADER_SATURATE_EN maps the most-negative input code to its symmetric value.
module ext_ram_loader
  import ext_ram_loader_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned FRAME_LEN  = DEFAULT_FRAME_LEN
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  frame_full,
  input  logic                  rd_start,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data_in,
  output logic                  ram_write_en,
  output logic                  ram_chip_sel,
  input  logic [DATA_WIDTH-1:0] ram_data_out
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  state_t                  state;
  state_t                  state_next;
  logic   [CNT_WIDTH-1:0]  wr_cnt;
  logic   [CNT_WIDTH-1:0]  rd_cnt;
  logic                    wr_last;
  logic                    rd_last;
  logic                    wr_en;
  logic                    rd_en;
  logic                    rd_done;
  logic   [DATA_WIDTH-1:0] wdata;

`ifdef LOADER_SATURATE_EN
  localparam logic [DATA_WIDTH-1:0] MIN_CODE = {1'b1, {(DATA_WIDTH - 1) {1'b0}}};
  localparam logic [DATA_WIDTH-1:0] SAT_CODE = MIN_CODE | DATA_WIDTH'(1);

  assign wdata = (in_data == MIN_CODE) ? SAT_CODE : in_data;
`else
  assign wdata = in_data;
`endif

  frame_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .FRAME_LEN (FRAME_LEN)
  ) u_wr_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (wr_en),
    .count  (wr_cnt),
    .last_c (wr_last)
  );

  frame_counter #(
    .CNT_WIDTH (CNT_WIDTH),
    .FRAME_LEN (FRAME_LEN)
  ) u_rd_cnt (
    .clk    (clk),
    .rst    (rst),
    .en     (rd_en),
    .count  (rd_cnt),
    .last_c (rd_last)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= LOAD;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the RAM port, which must follow the handshake in the same cycle.
  always_comb begin
    state_next   = state;
    in_ready     = 1'b0;
    wr_en        = 1'b0;
    rd_en        = 1'b0;
    ram_write_en = 1'b0;
    ram_chip_sel = 1'b0;
    ram_address  = '0;
    ram_data_in  = '0;
    case (state)
      LOAD: begin
        in_ready = !rst;
        if (in_valid && in_ready) begin
          wr_en        = 1'b1;
          ram_write_en = 1'b1;
          ram_chip_sel = 1'b1;
          ram_address  = ADDR_WIDTH'(wr_cnt);
          ram_data_in  = wdata;
          if (wr_last) begin
            state_next = FULL;
          end
        end
      end
      FULL: begin
        if (rd_start) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!rd_done && (!out_valid || out_ready)) begin
          rd_en        = 1'b1;
          ram_chip_sel = 1'b1;
          ram_address  = ADDR_WIDTH'(rd_cnt);
        end
        if (rd_done && out_valid && out_ready) begin
          state_next = LOAD;
        end
      end
      default: begin
        state_next = LOAD;
      end
    endcase
  end

  assign frame_full = (state == FULL);

  // Output register; rd_done marks that every word of the frame has been fetched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      rd_done   <= 1'b0;
    end else begin
      if (rd_en) begin
        out_data  <= ram_data_out;
        out_valid <= 1'b1;
        if (rd_last) begin
          rd_done <= 1'b1;
        end
      end else if (out_ready) begin
        out_valid <= 1'b0;
        if (rd_done && out_valid) begin
          rd_done <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_ext_ram_loader.sv
// Directed bench for ext_ram_loader with a 4-word frame and a behavioural RAM.
module tb_ext_ram_loader;

  logic              clk;
  logic              rst;
  logic signed [7:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              frame_full;
  logic              rd_start;
  logic signed [7:0] out_data;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        ram_address;
  logic signed [7:0] ram_data_in;
  logic              ram_write_en;
  logic              ram_chip_sel;
  logic signed [7:0] ram_data_out;

  logic signed [7:0] mem [4];

  int checks = 0;
  int errors = 0;

  ext_ram_loader #(
    .DATA_WIDTH (8),
    .ADDR_WIDTH (2),
    .FRAME_LEN  (4)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in_data      (in_data),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .frame_full   (frame_full),
    .rd_start     (rd_start),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ram_address  (ram_address),
    .ram_data_in  (ram_data_in),
    .ram_write_en (ram_write_en),
    .ram_chip_sel (ram_chip_sel),
    .ram_data_out (ram_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_chip_sel && ram_write_en) begin
      mem[ram_address] <= ram_data_in;
    end
  end
  assign ram_data_out = mem[ram_address];

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic write_frame(input logic signed [7:0] w0, input logic signed [7:0] w1,
                             input logic signed [7:0] w2, input logic signed [7:0] w3,
                             input string tag);
    logic signed [7:0] words [4];
    words[0] = w0; words[1] = w1; words[2] = w2; words[3] = w3;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = words[i];
      #1;
      chk({tag, "_addr"}, 32'(ram_address), i);
      chk({tag, "_we"}, 32'(ram_write_en), 1);
      chk({tag, "_cs"}, 32'(ram_chip_sel), 1);
      chk({tag, "_full_early"}, 32'(frame_full), 0);
      tick();
    end
    in_valid = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    rd_start  = 1'b0;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) mem[i] = 8'sd0;

    // Reset values
    tick();
    tick();
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_frame_full", 32'(frame_full), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_we", 32'(ram_write_en), 0);
    chk("rst_cs", 32'(ram_chip_sel), 0);
    chk("rst_addr", 32'(ram_address), 0);
    rst = 1'b0;
    #1;
    chk("load_in_ready", 32'(in_ready), 1);

    // rd_start ignored in LOAD
    rd_start = 1'b1;
    #1;
    chk("rdload_we", 32'(ram_write_en), 0);
    chk("rdload_cs", 32'(ram_chip_sel), 0);
    tick();
    rd_start = 1'b0;
    chk("rdload_in_ready", 32'(in_ready), 1);
    chk("rdload_full", 32'(frame_full), 0);

    // Partial frame then reset: next frame restarts at address 0
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_data  = 8'(8'sd11 * (i + 1));
      #1;
      chk("part_addr", 32'(ram_address), i);
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 0);
    chk("midrst_we", 32'(ram_write_en), 0);
    chk("midrst_addr", 32'(ram_address), 0);
    chk("midrst_full", 32'(frame_full), 0);
    chk("midrst_mem1", mem[1], 22);
    tick();
    rst = 1'b0;
    #1;

    // Full frame load
    write_frame(8'sd75, 8'sd13, 8'sd24, -8'sd5, "wr1");
    chk("wr1_full", 32'(frame_full), 1);
    chk("wr1_in_ready", 32'(in_ready), 0);
    chk("wr1_mem0", mem[0], 75);
    chk("wr1_mem1", mem[1], 13);
    chk("wr1_mem2", mem[2], 24);
    chk("wr1_mem3", mem[3], -5);
    in_valid = 1'b1;
    in_data  = 8'sd99;
    #1;
    chk("full_no_write", 32'(ram_write_en), 0);
    tick();
    in_valid = 1'b0;
    chk("full_hold", 32'(frame_full), 1);
    chk("full_mem0", mem[0], 75);

    // Drain with out_ready held high
    rd_start  = 1'b1;
    out_ready = 1'b1;
    tick();
    rd_start = 1'b0;
    chk("dr1_full_clr", 32'(frame_full), 0);
    chk("dr1_cs0", 32'(ram_chip_sel), 1);
    chk("dr1_we0", 32'(ram_write_en), 0);
    chk("dr1_addr0", 32'(ram_address), 0);
    chk("dr1_valid_lat", 32'(out_valid), 0);
    tick();
    chk("dr1_w0", out_data, 75);
    chk("dr1_v0", 32'(out_valid), 1);
    tick();
    chk("dr1_w1", out_data, 13);
    tick();
    chk("dr1_w2", out_data, 24);
    tick();
    chk("dr1_w3", out_data, -5);
    chk("dr1_v3", 32'(out_valid), 1);
    chk("dr1_no_read", 32'(ram_chip_sel), 0);
    tick();
    chk("dr1_done_valid", 32'(out_valid), 0);
    chk("dr1_done_ready", 32'(in_ready), 1);

    // Drain with a 3-cycle stall on word 13
    write_frame(8'sd75, 8'sd13, 8'sd24, -8'sd5, "wr2");
    rd_start = 1'b1;
    tick();
    rd_start = 1'b0;
    tick();
    chk("dr2_w0", out_data, 75);
    tick();
    chk("dr2_w1", out_data, 13);
    out_ready = 1'b0;
    #1;
    chk("stall_cs_now", 32'(ram_chip_sel), 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_data", out_data, 13);
      chk("stall_valid", 32'(out_valid), 1);
      chk("stall_cs", 32'(ram_chip_sel), 0);
      chk("stall_addr", 32'(ram_address), 0);
    end
    out_ready = 1'b1;
    #1;
    chk("resume_addr", 32'(ram_address), 2);
    chk("resume_cs", 32'(ram_chip_sel), 1);
    tick();
    chk("dr2_w2", out_data, 24);
    tick();
    chk("dr2_w3", out_data, -5);
    tick();
    chk("dr2_done_valid", 32'(out_valid), 0);
    chk("dr2_done_ready", 32'(in_ready), 1);

    // Most-negative code handling
    in_valid = 1'b1;
    in_data  = -8'sd128;
    #1;
`ifdef LOADER_SATURATE_EN
    chk("sat_wdata", ram_data_in, -127);
`else
    chk("sat_wdata", ram_data_in, -128);
`endif
    in_valid = 1'b0;
    in_data  = '0;
    #1;
    write_frame(-8'sd128, 8'sd1, 8'sd2, 8'sd3, "wr3");
`ifdef LOADER_SATURATE_EN
    chk("sat_mem0", mem[0], -127);
`else
    chk("sat_mem0", mem[0], -128);
`endif
    chk("sat_mem3", mem[3], 3);
    chk("sat_full", 32'(frame_full), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
